// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH = 16;

    // Counter must hold 0..w-1 without wrapping inside one division.
    function automatic int div_cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/sub_borrow_n.sv
// Ripple-borrow subtractor (a - b) built from per-bit full-subtractor cells.
// Latency: combinational. Backpressure: none.
// Borrow ripples from bit 0 upward; borrow_out=1 means a < b.
module sub_borrow_n #(
    parameter int N = 17
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] difference,
    output logic         borrow_out
);

    logic [N:0] bw;

    assign bw[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_cell
        assign difference[i] = a[i] ^ b[i] ^ bw[i];
        assign bw[i+1]       = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
    end

    assign borrow_out = bw[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider, one quotient bit per clock; DIV_ZERO_CHECK_EN short-cuts x/0.
// Latency: start to done = WIDTH+1 cycles (1 cycle for x/0 with DIV_ZERO_CHECK_EN).
// Backpressure: start is ignored while busy; results hold until the next accepted start.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = div_cnt_width(WIDTH);

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH:0]   r_reg;
    logic [WIDTH-1:0] dvs;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;
    logic             r_msb_unused;

    // R[WIDTH] is shifted out every iteration and never feeds the next one.
    assign r_msb_unused = r_reg[WIDTH];
    assign r_shift      = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};

    sub_borrow_n #(.N(WIDTH + 1)) u_sub (
        .a          (r_shift),
        .b          ({1'b0, dvs}),
        .difference (diff),
        .borrow_out (borrow)
    );

    assign r_next = borrow ? r_shift : diff;
    assign q_next = {q_reg[WIDTH-2:0], ~borrow};

`ifdef DIV_ZERO_CHECK_EN
    logic dbz_q;
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            q_reg     <= '0;
            r_reg     <= '0;
            dvs       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
`ifdef DIV_ZERO_CHECK_EN
            dbz_q     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        q_reg <= dividend;
                        dvs   <= divisor;
                        r_reg <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
`ifdef DIV_ZERO_CHECK_EN
                        if (divisor == '0) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            quotient  <= '1;
                            remainder <= dividend;
                            dbz_q     <= 1'b1;
                        end else begin
                            state <= RUN;
                            dbz_q <= 1'b0;
                        end
`else
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    q_reg <= q_next;
                    r_reg <= r_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        quotient  <= q_next;
                        remainder <= r_next[WIDTH-1:0];
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and random checks of seq_restoring_divider (WIDTH=16) against an arithmetic model.
module tb_seq_restoring_divider;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_assert = 0;
    int n_fail   = 0;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

`ifdef DIV_ZERO_CHECK_EN
    localparam bit ZCHK = 1'b1;
`else
    localparam bit ZCHK = 1'b0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model_q(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == 0) ? {W{1'b1}} : W'(a / b);
    endfunction

    function automatic logic [W-1:0] model_r(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == 0) ? a : W'(a % b);
    endfunction

    function automatic int model_lat(input logic [W-1:0] b);
        return (ZCHK && b == 0) ? 1 : W + 1;
    endfunction

    // One division from IDLE: accept, wait for done, check results, step back into IDLE.
    task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        int c;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start = 1'b0;
        c = 1;
        chk({tag, "_busy_start"}, 32'(busy), 32'd1);
        while (!done && c < 60) begin
            tick();
            c++;
        end
        chk({tag, "_latency"}, 32'(c), 32'(model_lat(b)));
        chk({tag, "_quot"}, 32'(quotient), 32'(model_q(a, b)));
        chk({tag, "_rem"}, 32'(remainder), 32'(model_r(a, b)));
        chk({tag, "_dbz"}, 32'(div_by_zero), 32'(ZCHK && b == 0));
        tick();
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           c;
        logic         saw_done;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_quot", 32'(quotient), 32'd0);
        chk("rst_rem", 32'(remainder), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        tick();

        run_div("t1_100_7", 16'd100, 16'd7);
        run_div("t2_ffff_1", 16'hFFFF, 16'd1);
        run_div("t2_5_9", 16'd5, 16'd9);
        run_div("t3_1234_0", 16'd1234, 16'd0);
        run_div("t3_10_3", 16'd10, 16'd3);

        // Scenario 4: start requests while busy are ignored; results hold during RUN.
        dividend = 16'd50;
        divisor  = 16'd5;
        start    = 1'b1;
        tick();
        for (int cyc = 1; cyc <= 17; cyc++) begin
            if (cyc == 4 || cyc == 17) begin
                start    = 1'b1;
                dividend = 16'd9;
                divisor  = 16'd2;
            end else begin
                start = 1'b0;
            end
            if (cyc == 10) begin
                chk("t4_quot_hold", 32'(quotient), 32'd3);
                chk("t4_rem_hold", 32'(remainder), 32'd1);
            end
            if (cyc == 17) begin
                chk("t4_done17", 32'(done), 32'd1);
                chk("t4_quot", 32'(quotient), 32'd10);
                chk("t4_rem", 32'(remainder), 32'd0);
            end
            tick();
        end
        // Cycle 18: IDLE with start held high.
        start    = 1'b1;
        dividend = 16'd9;
        divisor  = 16'd2;
        chk("t4_idle18", 32'(busy), 32'd0);
        tick();
        chk("t4_relaunch", 32'(busy), 32'd1);
        c = 1;
        while (!done && c < 60) begin
            tick();
            c++;
        end
        chk("t4_lat2", 32'(c), 32'd17);
        chk("t4_quot2", 32'(quotient), 32'd4);
        chk("t4_rem2", 32'(remainder), 32'd1);
        tick();
        chk("t4_idle_gap", 32'(busy), 32'd0);
        tick();
        chk("t4_relaunch2", 32'(busy), 32'd1);
        start = 1'b0;
        c = 1;
        while (!done && c < 60) begin
            tick();
            c++;
        end
        chk("t4_lat3", 32'(c), 32'd17);
        chk("t4_quot3", 32'(quotient), 32'd4);
        tick();

        // Scenario 5: asynchronous reset mid-division.
        dividend = 16'd40000;
        divisor  = 16'd3;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc < 8; cyc++) tick();
        chk("t5_busy_pre", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_done", 32'(done), 32'd0);
        chk("t5_rst_quot", 32'(quotient), 32'd0);
        chk("t5_rst_rem", 32'(remainder), 32'd0);
        saw_done = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        chk("t5_no_done", 32'(saw_done), 32'd0);
        rst_n = 1'b1;
        tick();
        run_div("t5_40000_3", 16'd40000, 16'd3);

        // Scenario 6: boundary cases and back-to-back random vectors.
        run_div("t6_eq", 16'd777, 16'd777);
        run_div("t6_lt", 16'd12, 16'd4000);
        run_div("t6_8000", 16'hFFFF, 16'h8000);
        run_div("t6_8000b", 16'h7FFF, 16'h8000);
        run_div("t6_zero_dvd", 16'd0, 16'd5);
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            case (i % 8)
                0: rb = W'($urandom_range(1, 15));
                1: rb = ra;
                2: rb = 16'h8000;
                3: rb = (ra == 16'hFFFF) ? ra : W'($urandom_range(int'(ra) + 1, 16'hFFFF));
                4: rb = (i % 64 == 4) ? 16'd0 : W'($urandom);
                default: rb = W'($urandom);
            endcase
            run_div("t6_rand", ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
